hazard_sequencer: RTL and testbench

Sequences the pipeline-register controls by producing the 2-bit `hazType` code every cycle. The code drives the pipeline register controller, which decodes it into `nop`, `flush` and the per-stage `stall` bits. The block sits in the ID stage:

- detects load-use hazards;
- schedules taken-branch/jump flushes, including multi-cycle flush windows;
- holds the whole pipeline while a data-memory access is outstanding, with a wait timeout.

It also keeps saturating stall and flush performance counters.

---
 rtl/hazard_sequencer.sv | 127 ++++++++++++
 tb/tb_hazard_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/hazard_sequencer.sv
// ID-stage hazard sequencer: load-use stalls, branch/jump flush windows and
// memory-wait holds, encoded as hazType for the pipeline register controller.
module hazard_sequencer #(
  parameter int WAIT_LIMIT   = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_usesRt,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic [1:0]       hazType,
  output logic             mem_timeout,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WCW = $clog2(WAIT_LIMIT + 1);
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [WCW-1:0] WLIM  = WCW'(WAIT_LIMIT);
  localparam logic [FCW-1:0] FINIT = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {RUN, MEMWAIT, FLUSH} state_t;

  state_t         state, state_n;
  logic [WCW-1:0] wcnt, wcnt_n;
  logic [FCW-1:0] fcnt, fcnt_n;
  logic [1:0]     haz;
  logic           timeout_set;
  logic           loaduse, memwait, redirect;

  assign loaduse  = ex_memRead && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (id_usesRt && (ex_rt == id_rt)));
  assign memwait  = mem_req && !mem_ready;
  assign redirect = branch_taken || jump;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= RUN;
      wcnt        <= '0;
      fcnt        <= '0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      fcnt  <= fcnt_n;
      if (timeout_set)
        mem_timeout <= 1'b1;
      // haz[0] marks both stall codes (01 and 11); counters saturate
      if (haz[0] && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if ((haz == 2'b10) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    fcnt_n      = fcnt;
    haz         = 2'b00;
    timeout_set = 1'b0;
    unique case (state)
      RUN: begin
        if (memwait) begin
          haz     = 2'b11;
          state_n = MEMWAIT;
          wcnt_n  = WCW'(1);
        end else if (loaduse) begin
          haz = 2'b01;
        end else if (redirect) begin
          haz = 2'b10;
          if (FLUSH_CYCLES > 1) begin
            state_n = FLUSH;
            fcnt_n  = FINIT;
          end
        end
      end
      MEMWAIT: begin
        // On completion the cycle behaves like RUN without the memory term
        if (mem_ready) begin
          state_n = RUN;
          if (loaduse) begin
            haz = 2'b01;
          end else if (redirect) begin
            haz = 2'b10;
            if (FLUSH_CYCLES > 1) begin
              state_n = FLUSH;
              fcnt_n  = FINIT;
            end
          end
        end else if (wcnt < WLIM) begin
          haz    = 2'b11;
          wcnt_n = wcnt + 1'b1;
        end else begin
          timeout_set = 1'b1;
          state_n     = RUN;
        end
      end
      FLUSH: begin
        if (memwait) begin
          haz = 2'b11;
        end else begin
          haz    = 2'b10;
          fcnt_n = fcnt - 1'b1;
          if (fcnt == FCW'(1))
            state_n = RUN;
        end
      end
      default: state_n = RUN;
    endcase
  end

  assign hazType = rstn ? haz : 2'b00;
  assign busy    = rstn && (state != RUN);

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed scoreboard bench for hazard_sequencer (WAIT_LIMIT=4, FLUSH_CYCLES=3,
// CNT_W=4); expected hazType/busy are queued as each step is driven.
module tb_hazard_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       ex_memRead;
  logic [4:0] ex_rt, id_rs, id_rt;
  logic       id_usesRt, branch_taken, jump, mem_req, mem_ready;
  logic [1:0] hazType;
  logic       mem_timeout, busy;
  logic [3:0] stall_cnt, flush_cnt;

  typedef struct {
    string      tag;
    logic [1:0] haz;
    logic       busy;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;

  hazard_sequencer #(.WAIT_LIMIT(4), .FLUSH_CYCLES(3), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .ex_memRead(ex_memRead), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_usesRt(id_usesRt),
    .branch_taken(branch_taken), .jump(jump), .mem_req(mem_req),
    .mem_ready(mem_ready), .hazType(hazType), .mem_timeout(mem_timeout),
    .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Pops the oldest expectation and compares it against the live outputs
  task automatic checkOutput();
    exp_t e;
    if (expq.size() == 0) begin
      checks++;
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = expq.pop_front();
      checkVal({e.tag, "_haz"}, {6'd0, hazType}, {6'd0, e.haz});
      checkVal({e.tag, "_busy"}, {7'd0, busy}, {7'd0, e.busy});
    end
  endtask

  // Drives one cycle of inputs, queues its expectation, checks mid-cycle,
  // then advances past the rising edge
  task automatic applyStimulus(input string tag, input logic rst_n,
                               input logic mr, input logic [4:0] ert,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic urt, input logic br, input logic jp,
                               input logic req, input logic rdy,
                               input logic [1:0] ehaz, input logic ebusy);
    exp_t e;
    rstn = rst_n; ex_memRead = mr; ex_rt = ert; id_rs = rs; id_rt = rt;
    id_usesRt = urt; branch_taken = br; jump = jp; mem_req = req; mem_ready = rdy;
    e.tag = tag; e.haz = ehaz; e.busy = ebusy;
    expq.push_back(e);
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag, input logic [1:0] ehaz, input logic ebusy);
    applyStimulus(tag, 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, ehaz, ebusy);
  endtask

  initial begin
    @(posedge clk);
    #1;
    // Reset held with every input high
    for (int i = 0; i < 3; i++)
      applyStimulus("reset", 1'b0, 1, 5'd31, 5'd31, 5'd31, 1, 1, 1, 1, 1, 2'b00, 1'b0);
    checkVal("reset_stall_cnt", {4'd0, stall_cnt}, 8'd0);
    checkVal("reset_flush_cnt", {4'd0, flush_cnt}, 8'd0);
    checkVal("reset_timeout", {7'd0, mem_timeout}, 8'd0);
    idle("idle0", 2'b00, 1'b0);

    // Load-use via rs, then the bubble cycle
    applyStimulus("lu_rs", 1'b1, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, 2'b01, 1'b0);
    idle("lu_after", 2'b00, 1'b0);
    checkVal("lu_stall_cnt", {4'd0, stall_cnt}, 8'd1);
    applyStimulus("lu_r0", 1'b1, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 2'b00, 1'b0);
    applyStimulus("lu_rt", 1'b1, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0, 0, 2'b01, 1'b0);
    applyStimulus("lu_rt_unused", 1'b1, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, 0, 2'b00, 1'b0);
    checkVal("lu_stall_cnt2", {4'd0, stall_cnt}, 8'd2);

    // Memory wait of 4 cycles then ready
    applyStimulus("mw1", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("mw_n", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 2'b11, 1'b1);
    applyStimulus("mw_ready", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 2'b00, 1'b1);
    applyStimulus("mw_first_ready", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 2'b00, 1'b0);
    checkVal("mw_stall_cnt", {4'd0, stall_cnt}, 8'd6);
    checkVal("mw_no_timeout", {7'd0, mem_timeout}, 8'd0);

    // Timeout: ready never arrives
    applyStimulus("to1", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 2'b11, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus("to_n", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 2'b11, 1'b1);
    applyStimulus("to_abandon", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 2'b00, 1'b1);
    checkVal("to_flag", {7'd0, mem_timeout}, 8'd1);
    idle("to_idle", 2'b00, 1'b0);
    checkVal("to_sticky", {7'd0, mem_timeout}, 8'd1);
    checkVal("to_stall_cnt", {4'd0, stall_cnt}, 8'd10);

    // Three-cycle flush window from a jump pulse
    applyStimulus("fl_jump", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 2'b10, 1'b0);
    idle("fl_2", 2'b10, 1'b1);
    idle("fl_3", 2'b10, 1'b1);
    idle("fl_done", 2'b00, 1'b0);
    checkVal("fl_flush_cnt", {4'd0, flush_cnt}, 8'd3);

    // Flush interrupted by memory wait; load-use ignored inside the window
    applyStimulus("flm_jump", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 2'b10, 1'b0);
    applyStimulus("flm_wait1", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 2'b11, 1'b1);
    applyStimulus("flm_wait2", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 2'b11, 1'b1);
    applyStimulus("flm_resume", 1'b1, 1, 5'd9, 5'd9, 5'd0, 0, 1, 0, 0, 0, 2'b10, 1'b1);
    idle("flm_last", 2'b10, 1'b1);
    idle("flm_done", 2'b00, 1'b0);
    checkVal("flm_flush_cnt", {4'd0, flush_cnt}, 8'd6);
    checkVal("flm_stall_cnt", {4'd0, stall_cnt}, 8'd12);

    // Priority: memory wait beats load-use and branch; then ready + load-use
    applyStimulus("pri_all", 1'b1, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 1, 0, 2'b11, 1'b0);
    applyStimulus("pri_ready_lu", 1'b1, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 1, 1, 2'b01, 1'b1);
    applyStimulus("pri_lu_br", 1'b1, 1, 5'd3, 5'd3, 5'd0, 0, 1, 0, 0, 0, 2'b01, 1'b0);
    applyStimulus("pri_br", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 2'b10, 1'b0);
    idle("pri_fl2", 2'b10, 1'b1);
    idle("pri_fl3", 2'b10, 1'b1);
    checkVal("pri_stall_cnt", {4'd0, stall_cnt}, 8'd15);
    checkVal("pri_flush_cnt", {4'd0, flush_cnt}, 8'd9);

    // Stall counter saturation at 15
    for (int i = 0; i < 20; i++)
      applyStimulus("sat_lu", 1'b1, 1, 5'd12, 5'd12, 5'd0, 0, 0, 0, 0, 0, 2'b01, 1'b0);
    checkVal("sat_stall_cnt", {4'd0, stall_cnt}, 8'd15);

    // Reset in the middle of a flush window aborts it
    applyStimulus("rst_jump", 1'b1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, 2'b10, 1'b0);
    applyStimulus("rst_mid", 1'b0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 2'b00, 1'b0);
    idle("rst_after", 2'b00, 1'b0);
    checkVal("rst_stall_cnt", {4'd0, stall_cnt}, 8'd0);
    checkVal("rst_flush_cnt", {4'd0, flush_cnt}, 8'd0);
    checkVal("rst_timeout", {7'd0, mem_timeout}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
